// File: rtl/controller_mc_ws_if.sv
// controller_mc_ws_if: control/status bundle between the multicycle controller and its datapath/memory.
interface controller_mc_ws_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero, lt, ltu, mem_ready;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, done, fault;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;
    modport master (
        input  op, func3, func7, zero, lt, ltu, mem_ready,
        output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, done, fault,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );
    modport slave (
        output op, func3, func7, zero, lt, ltu, mem_ready,
        input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, done, fault,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );
endinterface

// File: rtl/controller_mc_ws.sv
// controller_mc_ws: multicycle RV32I control FSM with request/ready memory handshake and timeout fault.
module controller_mc_ws #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_UNSIGNED = 1'b1
) (
    input logic clk,
    input logic rst,
    controller_mc_ws_if.master c
);
    typedef enum logic [4:0] {
        FETCH, DECODE, MEMADR_L, MEMREAD, MEMWB, MEMADR_S, MEMWRITE, EXE_R, EXE_I, ALUWB,
        BRANCH, JALR_A, JALR_P, JAL_A, JAL_P, LINKWB, LUI, HALT
    } state_t;
    localparam int CW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CW-1:0] TO = CW'(MEM_TIMEOUT);
    state_t state, next;
    logic [CW-1:0] cnt;
    logic fault_r, waiting, tmo, take;
    logic [2:0] alu_op;
    assign waiting = state inside {FETCH, MEMREAD, MEMWRITE};
    assign tmo = waiting && !c.mem_ready && MEM_TIMEOUT != 0 && cnt == TO;
    assign take = (c.func3 == 3'b000 && c.zero) || (c.func3 == 3'b001 && !c.zero) ||
                  (c.func3 == 3'b100 && c.lt) || (c.func3 == 3'b101 && !c.lt) ||
                  (EN_UNSIGNED && ((c.func3 == 3'b110 && c.ltu) || (c.func3 == 3'b111 && !c.ltu)));
    assign alu_op = c.func3 == 3'b000 ? ((c.op == 7'b0110011 && c.func7 == 7'b0100000) ? 3'b001 : 3'b000) :
                    c.func3 == 3'b111 ? 3'b010 :
                    c.func3 == 3'b110 ? 3'b011 :
                    c.func3 == 3'b100 ? 3'b111 :
                    c.func3 == 3'b010 ? 3'b101 :
                    (c.func3 == 3'b011 && EN_UNSIGNED) ? 3'b110 : 3'b000;
    // counter is zero on entry to any wait state because it clears everywhere else
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            cnt     <= '0;
            fault_r <= 1'b0;
        end else begin
            state   <= next;
            cnt     <= (waiting && !c.mem_ready && !tmo) ? cnt + 1'b1 : '0;
            fault_r <= fault_r | tmo;
        end
    end
    always_comb begin
        next = state;
        case (state)
            FETCH:    next = tmo ? HALT : c.mem_ready ? DECODE : FETCH;
            DECODE:
                case (c.op)
                    7'b0000011: next = MEMADR_L;
                    7'b0100011: next = MEMADR_S;
                    7'b0110011: next = EXE_R;
                    7'b1100011: next = BRANCH;
                    7'b0010011: next = EXE_I;
                    7'b1100111: next = JALR_A;
                    7'b1101111: next = JAL_A;
                    7'b0110111: next = LUI;
                    default:    next = HALT;
                endcase
            MEMADR_L: next = MEMREAD;
            MEMREAD:  next = tmo ? HALT : c.mem_ready ? MEMWB : MEMREAD;
            MEMADR_S: next = MEMWRITE;
            MEMWRITE: next = tmo ? HALT : c.mem_ready ? FETCH : MEMWRITE;
            EXE_R, EXE_I, LUI: next = ALUWB;
            JALR_A:   next = JALR_P;
            JAL_A:    next = JAL_P;
            JALR_P, JAL_P: next = LINKWB;
            MEMWB, ALUWB, LINKWB, BRANCH: next = FETCH;
            default:  next = HALT;
        endcase
    end
    always_comb begin
        c.mem_req     = 1'b0;
        c.adr_src     = 1'b0;
        c.mem_write   = 1'b0;
        c.ir_write    = 1'b0;
        c.pc_write    = 1'b0;
        c.reg_write   = 1'b0;
        c.result_src  = 2'b00;
        c.alu_src_a   = 2'b00;
        c.alu_src_b   = 2'b00;
        c.imm_src     = 3'b000;
        c.alu_control = 3'b000;
        c.done        = 1'b0;
        c.fault       = 1'b0;
        if (!rst)
            case (state)
                FETCH: begin
                    c.mem_req    = 1'b1;
                    c.ir_write   = c.mem_ready;
                    c.pc_write   = c.mem_ready;
                    c.alu_src_b  = 2'b10;
                    c.result_src = 2'b10;
                end
                DECODE: begin
                    c.alu_src_a = 2'b01;
                    c.alu_src_b = 2'b01;
                    c.imm_src   = 3'b010;
                end
                MEMADR_L, JALR_A: begin
                    c.alu_src_a = 2'b10;
                    c.alu_src_b = 2'b01;
                end
                MEMADR_S: begin
                    c.alu_src_a = 2'b10;
                    c.alu_src_b = 2'b01;
                    c.imm_src   = 3'b001;
                end
                MEMREAD: begin
                    c.mem_req = 1'b1;
                    c.adr_src = 1'b1;
                end
                MEMWRITE: begin
                    c.mem_req   = 1'b1;
                    c.adr_src   = 1'b1;
                    c.mem_write = !tmo;
                end
                MEMWB: begin
                    c.result_src = 2'b01;
                    c.reg_write  = 1'b1;
                end
                EXE_R: begin
                    c.alu_src_a   = 2'b10;
                    c.alu_control = alu_op;
                end
                EXE_I: begin
                    c.alu_src_a   = 2'b10;
                    c.alu_src_b   = 2'b01;
                    c.alu_control = alu_op;
                end
                ALUWB, LINKWB: c.reg_write = 1'b1;
                BRANCH: begin
                    c.alu_src_a   = 2'b10;
                    c.alu_control = 3'b001;
                    c.pc_write    = take;
                end
                JALR_P, JAL_P: begin
                    c.pc_write  = 1'b1;
                    c.alu_src_a = 2'b01;
                    c.alu_src_b = 2'b10;
                end
                JAL_A: begin
                    c.alu_src_a = 2'b01;
                    c.alu_src_b = 2'b01;
                    c.imm_src   = 3'b011;
                end
                LUI: begin
                    c.alu_src_b   = 2'b01;
                    c.imm_src     = 3'b100;
                    c.alu_control = 3'b100;
                end
                HALT: begin
                    c.done  = 1'b1;
                    c.fault = fault_r;
                end
                default: ;
            endcase
    end
endmodule

// File: doc/controller_mc_ws.md
# controller_mc_ws

Multicycle RV32I control unit with variable-latency memory support. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq/bne/blt/bge/bltu/bgeu, jalr, jal and lui. Every memory access uses a request/ready handshake with a bounded timeout, so the datapath can sit in front of a slow or shared memory. It drives the existing multicycle datapath and adds a `mem_req` output, a `fault` output and the `ltu` and `mem_ready` inputs.

## Interface
- Clock/reset: one clock; reset is synchronous and active-high; ports named `clk` and `rst`.
- `MEM_TIMEOUT`, default 16: wait cycles allowed per memory access before a fault; 0 disables the timeout.
- `EN_UNSIGNED`, default 1: 1 enables bltu/bgeu branches and sltu/sltiu; 0 makes them not-taken / add.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `op` in 7: instruction opcode field.
- `func3` in 3: instruction func3 field.
- `func7` in 7: instruction func7 field.
- `zero` in 1: ALU result == 0.
- `lt` in 1: signed A<B.
- `ltu` in 1: unsigned A<B.
- `mem_ready` in 1: memory completed the current access this cycle.
- `mem_req` out 1: memory access active.
- `adr_src` out 1: 0 = PC address, 1 = ALU-result address.
- `mem_write` out 1: the active access is a write.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC.
- `reg_write` out 1: write the register file.
- `result_src` out 2: 00 ALUOut, 01 memory data, 10 ALU result.
- `alu_src_a` out 2: 00 PC, 01 OldPC, 10 rs1 register.
- `alu_src_b` out 2: 00 rs2 register, 01 immediate, 10 constant 4.
- `imm_src` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 100 pass B, 101 slt, 110 sltu, 111 xor.
- `done` out 1: halted.
- `fault` out 1: halted because of a memory timeout.

## Operation
- While `rst`=1, every output is forced to 0. On the clock edge with `rst`=1, the state becomes FETCH and the wait counter clears.
- **FETCH:** `mem_req`=1, `adr_src`=0, `alu_src_b`=10, `result_src`=10.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1; the state then advances to DECODE.
  - Otherwise the state holds in FETCH.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01, `imm_src`=010. Next state by opcode:
  - 0000011 → MEMADR_L
  - 0100011 → MEMADR_S
  - 0110011 → EXE_R
  - 1100011 → BRANCH
  - 0010011 → EXE_I
  - 1100111 → JALR_A
  - 1101111 → JAL_A
  - 0110111 → LUI
  - any other opcode → HALT (`done`=1, `fault`=0).
- **BRANCH:** `alu_src_a`=10, `alu_control`=sub. `pc_write` = (000 & zero) | (001 & !zero) | (100 & lt) | (101 & !lt) | (EN_UNSIGNED & ((110 & ltu) | (111 & !ltu))). Next state FETCH.
- **Load path:**
  - MEMADR_L: `alu_src_a`=10, `alu_src_b`=01.
  - MEMREAD: `mem_req`=1, `adr_src`=1; waits for `mem_ready`.
  - MEMWB: `result_src`=01, `reg_write`=1.
- **Store path:**
  - MEMADR_S: adds `imm_src`=001.
  - MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1; waits for `mem_ready`, then FETCH.
- **ALU paths:**
  - EXE_R: `alu_src_a`=10, `alu_src_b`=00.
  - EXE_I: `alu_src_a`=10, `alu_src_b`=01.
  - Both then go to ALUWB (`reg_write`=1).
- **ALU decode for EXE_R/EXE_I**, by func3:
  - 000 → sub only if op=0110011 and func7=0100000, else add
  - 111 → and
  - 110 → or
  - 100 → xor
  - 010 → slt
  - 011 → sltu if EN_UNSIGNED, else add
  - others → add
- **JALR:**
  - JALR_A: `alu_src_a`=10, `alu_src_b`=01.
  - JALR_P: `pc_write`=1, `alu_src_a`=01, `alu_src_b`=10.
  - LINKWB: `reg_write`=1.
- **JAL:**
  - JAL_A: `alu_src_a`=01, `alu_src_b`=01, `imm_src`=011.
  - JAL_P: same as JALR_P.
  - Then LINKWB.
- **LUI:** `imm_src`=100, `alu_src_b`=01, `alu_control`=pass B; then ALUWB.
- **Wait counter:**
  - Cleared whenever a wait state (FETCH, MEMREAD, MEMWRITE) is entered or completes.
  - Increments each cycle the block stays in a wait state with `mem_ready`=0.
  - When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with `mem_ready` still 0, the next state is HALT with `fault`=1. `ir_write`, `pc_write`, `reg_write` and `mem_write` are never asserted on the timeout cycle.
- **HALT:** `done`=1 and `fault` holds its captured value. All other outputs are 0. Only `rst` exits HALT.
- `mem_ready` outside a wait state is ignored.

## Timing
- All outputs are combinational from state plus `mem_ready`, `zero`, `lt`, `ltu`, `func3`, `func7` and `op`. The next state is registered on the `clk` rising edge.
- Zero-wait cycle counts (`mem_ready`=1 at first request):
  - branch 3
  - sw, R, I, lui 4
  - lw, jalr, jal 5
- Each `mem_ready`=0 cycle in a wait state adds exactly 1 cycle.
- With MEM_TIMEOUT=N, a stuck access leaves the wait state after N+1 cycles total; `done`=`fault`=1 from the next cycle.
- `rst` asserted mid-instruction aborts it. No write strobe is asserted in the reset cycle, and fetch restarts the cycle after `rst` falls.

## Test plan
- **Zero-wait add x3,x1,x2** (op 0110011, func3 000, func7 0) → `alu_control`=000 in EXE_R, `reg_write`=1 in cycle 4, back to FETCH in cycle 5.
- **lw with `mem_ready` low 3 cycles in FETCH and 2 in MEMREAD** → 10 cycles total, `ir_write` pulsed exactly once in cycle 4, `reg_write` in cycle 10.
- **bltu with `ltu`=1**: EN_UNSIGNED=1 → `pc_write`=1 in BRANCH; EN_UNSIGNED=0 → `pc_write`=0.
- **MEM_TIMEOUT=4, `mem_ready` held 0 in MEMWRITE** → 5 cycles in MEMWRITE, then `done`=1 and `fault`=1, `mem_write` not asserted afterwards; `rst` clears both outputs.
- **Opcode 0000000** → HALT after DECODE with `done`=1, `fault`=0, held for 20 cycles.
- **`rst` pulsed during JALR_P** → no `reg_write`; all outputs 0 during `rst`; next cycle `mem_req`=1, `adr_src`=0.
